pc_sequencer_rv32i: RTL and testbench
=====================================

PC_SEQUENCER_RV32I -- requirements
Module: pc_sequencer_rv32i

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, PC loaded on reset (word-aligned).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  fetch address; equals pc.
REQ-006 SHALL have port imem_ready  input  1  memory accepts request and returns instruction this cycle.
REQ-007 SHALL have port instr_valid  output  1  fetched instruction held for execute.
REQ-008 SHALL have port retire  input  1  execute has finished the current instruction.
REQ-009 SHALL have port stall  input  1  hold the current instruction; retire is ignored while high.
REQ-010 SHALL have port redirect_valid  input  1  taken branch/jump for the retiring instruction (from brancher).
REQ-011 SHALL have port redirect_target  input  32  branch/jump target address.
REQ-012 SHALL have port pc  output  32  address of the current instruction.
REQ-013 SHALL have port pc_plus4  output  32  pc + 4, fed to the brancher as the fall-through PC.
REQ-014 SHALL have port trap  output  1  misaligned-target trap; sticky until reset.
REQ-015 SHALL have port trap_addr  output  32  offending redirect_target latched at trap entry.
REQ-016 SHALL have port retire_count  output  32  number of retired instructions.

Function
REQ-017 SHALL implement FSM states BOOT, FETCH, EXEC, HALT.
REQ-018 BOOT SHALL last exactly one cycle with imem_req=0, then go to FETCH.
REQ-019 FETCH SHALL drive imem_req=1 and imem_addr=pc; on imem_ready=1 it SHALL go to EXEC; otherwise it SHALL stay in FETCH indefinitely.
REQ-020 instr_valid SHALL be 1 exactly while the state is EXEC, asserting the cycle after the imem_ready handshake.
REQ-021 In EXEC with retire=1, stall=0 and redirect_valid=0, the block SHALL set pc <= pc+4, increment retire_count and go to FETCH.
REQ-022 In EXEC with retire=1, stall=0, redirect_valid=1 and redirect_target[1:0]==0, the block SHALL set pc <= redirect_target, increment retire_count and go to FETCH.
REQ-023 In EXEC with retire=1, stall=0, redirect_valid=1 and redirect_target[1:0]!=0, the block SHALL set trap=1 and trap_addr=redirect_target, go to HALT, and leave pc and retire_count unchanged.
REQ-024 In EXEC with stall=1, the block SHALL hold all state regardless of retire and redirect_valid.
REQ-025 redirect_valid and redirect_target SHALL be ignored outside an EXEC retire cycle.
REQ-026 HALT SHALL drive imem_req=0 and instr_valid=0 and SHALL be left only via rst.
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 retire_count SHALL wrap modulo 2^32.
REQ-029 pc_plus4 SHALL be combinational from pc.
REQ-030 Minimum instruction period SHALL be 2 cycles (FETCH with imem_ready=1, then EXEC with retire=1).

Reset
REQ-031 With rst=1 at a clock edge, the block SHALL set state=BOOT, pc=RESET_VECTOR, trap=0, trap_addr=0 and retire_count=0, from any state including mid-FETCH, EXEC or HALT.
REQ-032 While in reset, imem_req=0 and instr_valid=0.
REQ-033 rst SHALL take priority over imem_ready, retire and stall in the same cycle.

Structure
REQ-034 State encodings and the instruction width/step constant (4) SHALL live in a shared package rv32i_pkg.
REQ-035 The block SHALL be a single module with no sub-modules; the FSM, PC register, trap latch and counter reside inline.

Verification
REQ-036 Reset, then imem_ready=1 continuously and retire=1 in every EXEC -> imem_addr sequence 0x0, 0x4, 0x8, ...; retire_count=3 after three retires.
REQ-037 pc=0x10, EXEC, retire=1, redirect_valid=1, target=0x40 -> next FETCH imem_addr=0x40.
REQ-038 pc=0x10, EXEC, redirect target=0x42 -> trap=1, trap_addr=0x42, pc stays 0x10, imem_req=0 thereafter until rst.
REQ-039 EXEC with stall=1 and retire=1 for 3 cycles, then stall=0 -> pc and retire_count unchanged during the stall; advance by one step on release.
REQ-040 FETCH with imem_ready=0 for 5 cycles -> imem_req held at 1 with a stable address; rst asserted mid-EXEC -> BOOT, pc=RESET_VECTOR.
REQ-041 pc=0xFFFF_FFFC, retire without redirect -> pc=0x0000_0000.

Source files
------------

// File: rtl/rv32i_pkg.sv
//------------------------------------------------------------------------------
// rv32i_pkg : shared state encodings and step constants for the PC sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

  localparam int unsigned XLEN = 32;

  // Every RV32I instruction occupies one 32-bit word.
  localparam logic [XLEN-1:0] INSTR_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_rv32i.sv
//------------------------------------------------------------------------------
// pc_sequencer_rv32i : fetch/execute sequencer owning the PC, trap latch and
//                      retired-instruction counter for a multi-cycle RV32I core
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer_rv32i
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        instr_valid,
  input  logic        retire,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        trap,
  output logic [31:0] trap_addr,
  output logic [31:0] retire_count
);

  // Low bits forced clear so a mis-set parameter can never fetch misaligned.
  localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

  pc_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        trap_q, trap_d;
  logic [31:0] trap_addr_q, trap_addr_d;
  logic [31:0] retire_count_q, retire_count_d;

  logic        retire_fire;
  logic [31:0] pc_next_seq;

  assign pc_next_seq = pc_q + INSTR_STEP;
  assign retire_fire = (state_q == ST_EXEC) && retire && !stall;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    trap_d         = trap_q;
    trap_addr_d    = trap_addr_q;
    retire_count_d = retire_count_q;

    unique case (state_q)
      ST_BOOT: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ready) begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (retire_fire) begin
          if (!redirect_valid) begin
            pc_d           = pc_next_seq;
            retire_count_d = retire_count_q + 32'd1;
            state_d        = ST_FETCH;
          end else if (!is_misaligned(redirect_target)) begin
            pc_d           = redirect_target;
            retire_count_d = retire_count_q + 32'd1;
            state_d        = ST_FETCH;
          end else begin
            // Faulting instruction does not retire; pc keeps pointing at it.
            trap_d      = 1'b1;
            trap_addr_d = redirect_target;
            state_d     = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_BOOT;
      pc_q           <= RESET_PC;
      trap_q         <= 1'b0;
      trap_addr_q    <= 32'd0;
      retire_count_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      trap_q         <= trap_d;
      trap_addr_q    <= trap_addr_d;
      retire_count_q <= retire_count_d;
    end
  end

  // Reset masks the handshake outputs immediately, before the state flop updates.
  assign imem_req     = (state_q == ST_FETCH) && !rst;
  assign instr_valid  = (state_q == ST_EXEC) && !rst;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_next_seq;
  assign trap         = trap_q;
  assign trap_addr    = trap_addr_q;
  assign retire_count = retire_count_q;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer_rv32i.sv
//------------------------------------------------------------------------------
// tb_pc_sequencer_rv32i : directed + randomized bench for pc_sequencer_rv32i
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer_rv32i;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        instr_valid;
  logic        retire;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        trap;
  logic [31:0] trap_addr;
  logic [31:0] retire_count;

  int checks = 0;
  int errors = 0;

  pc_sequencer_rv32i #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .instr_valid     (instr_valid),
    .retire          (retire),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .trap            (trap),
    .trap_addr       (trap_addr),
    .retire_count    (retire_count)
  );

  always #5 clk = ~clk;

  // Reference model: phase of the instruction lifecycle plus architectural state.
  localparam int PH_BOOT = 0, PH_FETCH = 1, PH_EXEC = 2, PH_HALT = 3;
  int          m_phase;
  logic [31:0] m_pc, m_cnt, m_taddr;
  logic        m_trap;

  task automatic model_next();
    if (rst) begin
      m_phase = PH_BOOT; m_pc = 32'h0; m_cnt = 0; m_trap = 0; m_taddr = 0;
    end else if (m_phase == PH_BOOT) begin
      m_phase = PH_FETCH;
    end else if (m_phase == PH_FETCH) begin
      if (imem_ready) m_phase = PH_EXEC;
    end else if (m_phase == PH_EXEC && retire && !stall) begin
      if (redirect_valid && (redirect_target % 4) != 0) begin
        m_trap = 1; m_taddr = redirect_target; m_phase = PH_HALT;
      end else begin
        m_pc    = redirect_valid ? redirect_target : m_pc + 32'd4;
        m_cnt   = m_cnt + 32'd1;
        m_phase = PH_FETCH;
      end
    end
  endtask

  task automatic cycle();
    model_next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_ready = 0; retire = 0; stall = 0; redirect_valid = 0; redirect_target = 0;
  endtask

  task automatic go_exec();
    imem_ready = 1; retire = 0; stall = 0; redirect_valid = 0;
    for (int i = 0; i < 10 && m_phase != PH_EXEC; i++) cycle();
    imem_ready = 0;
    checks++;
    if (instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL reach_exec: instr_valid=%b required 1 (bounded wait)", instr_valid);
    end
  endtask

  task automatic jump_to(input logic [31:0] addr);
    go_exec();
    retire = 1; redirect_valid = 1; redirect_target = addr;
    cycle();
    retire = 0; redirect_valid = 0;
    go_exec();
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    cycle();
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; imem_ready = 1; retire = 1;
    cycle();
    checks++;
    if (imem_req !== 0 || instr_valid !== 0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b valid=%b required 0 0", imem_req, instr_valid);
    end
    checks++;
    if (pc !== 32'h0 || pc_plus4 !== 32'h4 || trap !== 0 || trap_addr !== 0 || retire_count !== 0) begin
      errors++;
      $display("FAIL reset_state: pc=%h p4=%h trap=%b taddr=%h cnt=%0d required 0 4 0 0 0",
               pc, pc_plus4, trap, trap_addr, retire_count);
    end
    rst = 0; imem_ready = 0; retire = 0;
    cycle();
    checks++;
    if (imem_req !== 1 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL boot_to_fetch: req=%b addr=%h required 1 00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    imem_ready = 1; retire = 1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4 && !imem_req; i++) cycle();
      checks++;
      if (imem_req !== 1 || imem_addr !== 32'(4 * k)) begin
        errors++;
        $display("FAIL seq_addr%0d: req=%b addr=%h required 1 %h", k, imem_req, imem_addr, 32'(4 * k));
      end
      cycle();
      checks++;
      if (instr_valid !== 1 || retire_count !== 32'(k)) begin
        errors++;
        $display("FAIL seq_exec%0d: valid=%b cnt=%0d required 1 %0d", k, instr_valid, retire_count, k);
      end
      if (k < 3) cycle();
    end
    checks++;
    if (retire_count !== 32'd3) begin
      errors++;
      $display("FAIL seq_count: cnt=%0d required 3", retire_count);
    end
    idle_inputs();
  endtask

  task automatic test_redirect();
    logic [31:0] c0;
    do_reset();
    jump_to(32'h10);
    c0 = retire_count;
    retire = 1; redirect_valid = 1; redirect_target = 32'h40;
    cycle();
    checks++;
    if (imem_req !== 1 || imem_addr !== 32'h40 || retire_count !== c0 + 1) begin
      errors++;
      $display("FAIL redirect: req=%b addr=%h cnt=%0d required 1 00000040 %0d",
               imem_req, imem_addr, retire_count, c0 + 1);
    end
    idle_inputs();
  endtask

  task automatic test_trap();
    logic [31:0] c0;
    do_reset();
    jump_to(32'h10);
    c0 = retire_count;
    retire = 1; redirect_valid = 1; redirect_target = 32'h42;
    cycle();
    retire = 1; redirect_valid = 1; redirect_target = 32'h80; imem_ready = 1;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (trap !== 1 || trap_addr !== 32'h42 || pc !== 32'h10 || retire_count !== c0 ||
          imem_req !== 0 || instr_valid !== 0) begin
        errors++;
        $display("FAIL trap_hold%0d: trap=%b taddr=%h pc=%h cnt=%0d req=%b valid=%b required 1 42 10 %0d 0 0",
                 i, trap, trap_addr, pc, retire_count, imem_req, instr_valid, c0);
      end
      cycle();
    end
    do_reset();
    checks++;
    if (trap !== 0 || trap_addr !== 0 || pc !== 0) begin
      errors++;
      $display("FAIL trap_clear: trap=%b taddr=%h pc=%h required 0 0 0", trap, trap_addr, pc);
    end
  endtask

  task automatic test_stall();
    logic [31:0] p0, c0;
    do_reset();
    jump_to(32'h100);
    p0 = pc; c0 = retire_count;
    stall = 1; retire = 1; redirect_valid = 1; redirect_target = 32'h43;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (pc !== p0 || retire_count !== c0 || instr_valid !== 1 || trap !== 0) begin
        errors++;
        $display("FAIL stall_hold%0d: pc=%h cnt=%0d valid=%b trap=%b required %h %0d 1 0",
                 i, pc, retire_count, instr_valid, trap, p0, c0);
      end
    end
    stall = 0; redirect_valid = 0;
    cycle();
    checks++;
    if (pc !== p0 + 4 || retire_count !== c0 + 1 || imem_req !== 1) begin
      errors++;
      $display("FAIL stall_release: pc=%h cnt=%0d req=%b required %h %0d 1",
               pc, retire_count, imem_req, p0 + 4, c0 + 1);
    end
    idle_inputs();
  endtask

  task automatic test_fetch_wait();
    logic [31:0] a0;
    do_reset();
    jump_to(32'h20);
    retire = 1;
    cycle();
    retire = 0; imem_ready = 0;
    a0 = imem_addr;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if (imem_req !== 1 || imem_addr !== a0 || imem_addr !== 32'h24) begin
        errors++;
        $display("FAIL fetch_wait%0d: req=%b addr=%h required 1 00000024", i, imem_req, imem_addr);
      end
    end
    go_exec();
    rst = 1; retire = 1; imem_ready = 1;
    cycle();
    rst = 0; retire = 0; imem_ready = 0;
    checks++;
    if (pc !== 32'h0 || imem_req !== 0 || instr_valid !== 0 || retire_count !== 0) begin
      errors++;
      $display("FAIL reset_mid_exec: pc=%h req=%b valid=%b cnt=%0d required 0 0 0 0",
               pc, imem_req, instr_valid, retire_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    jump_to(32'hFFFF_FFFC);
    checks++;
    if (pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_plus4: pc_plus4=%h required 00000000", pc_plus4);
    end
    retire = 1;
    cycle();
    checks++;
    if (pc !== 32'h0 || imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_pc: pc=%h addr=%h required 00000000", pc, imem_addr);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst             = ($urandom % 40) == 0;
      imem_ready      = $urandom % 2;
      retire          = $urandom % 2;
      stall           = ($urandom % 4) == 0;
      redirect_valid  = $urandom % 2;
      redirect_target = ($urandom % 8 == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      cycle();
      checks++;
      if (imem_req !== (!rst && m_phase == PH_FETCH) || instr_valid !== (!rst && m_phase == PH_EXEC) ||
          pc !== m_pc || imem_addr !== m_pc || pc_plus4 !== m_pc + 32'd4 ||
          trap !== m_trap || trap_addr !== m_taddr || retire_count !== m_cnt) begin
        errors++;
        $display("FAIL random%0d: req=%b valid=%b pc=%h trap=%b taddr=%h cnt=%0d required %b %b %h %b %h %0d",
                 i, imem_req, instr_valid, pc, trap, trap_addr, retire_count,
                 !rst && m_phase == PH_FETCH, !rst && m_phase == PH_EXEC, m_pc, m_trap, m_taddr, m_cnt);
      end
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    m_phase = PH_BOOT; m_pc = 0; m_cnt = 0; m_trap = 0; m_taddr = 0;
    test_reset();
    test_sequential();
    test_redirect();
    test_trap();
    test_stall();
    test_fetch_wait();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
